// File: rtl/wb_stage_if.sv
// Interface between the memory stage / hazard control and the writeback stage,
// carrying the MEM/WB inputs and the register-file, forwarding and status outputs.
interface wb_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic                      mem_valid;
  logic [DATA_WIDTH-1:0]     mem_load_data;
  logic [DATA_WIDTH-1:0]     mem_alu_result;
  logic [REG_ADDR_WIDTH-1:0] mem_dest_reg;
  logic                      mem_reg_write;
  logic                      mem_mem_to_reg;
  logic [1:0]                mem_instr_class;
  logic                      mem_is_halt;
  logic                      wb_stall;
  logic                      wb_flush;

  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;
  logic                      fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] fwd_reg;
  logic [DATA_WIDTH-1:0]     fwd_data;
  logic                      halted;
  logic [CNT_WIDTH-1:0]      cnt_total;
  logic [CNT_WIDTH-1:0]      cnt_arith;
  logic [CNT_WIDTH-1:0]      cnt_logic;
  logic [CNT_WIDTH-1:0]      cnt_mem;
  logic [CNT_WIDTH-1:0]      cnt_ctrl;

  modport master (
    output mem_valid, mem_load_data, mem_alu_result, mem_dest_reg, mem_reg_write,
           mem_mem_to_reg, mem_instr_class, mem_is_halt, wb_stall, wb_flush,
    input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data, halted,
           cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_ctrl
  );

  modport slave (
    input  mem_valid, mem_load_data, mem_alu_result, mem_dest_reg, mem_reg_write,
           mem_mem_to_reg, mem_instr_class, mem_is_halt, wb_stall, wb_flush,
    output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data, halted,
           cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_ctrl
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS-Lite writeback stage: MEM/WB register, register-file write port, forwarding
// source, saturating retirement counters and a sticky HALT state.
module wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t                    state, state_next;
  logic                      capture, bubble, retire;
  logic                      wb_valid, wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_dest;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [CNT_WIDTH-1:0]      cnt_total_q;
  logic [CNT_WIDTH-1:0]      cnt_class [4];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    capture    = 1'b0;
    bubble     = 1'b0;
    retire     = 1'b0;
    unique case (state)
      RUN: begin
        bubble  = bus.wb_flush;
        capture = !bus.wb_flush && !bus.wb_stall;
        retire  = capture && bus.mem_valid;
        if (retire && bus.mem_is_halt) state_next = HALTED;
      end
      HALTED: bubble = 1'b1;  // stall is ignored once halted
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest      <= '0;
      wb_data      <= '0;
    end else if (bubble) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest      <= '0;
      wb_data      <= '0;
    end else if (capture) begin
      wb_valid     <= bus.mem_valid;
      wb_reg_write <= bus.mem_reg_write && !bus.mem_is_halt;  // HALT never writes
      wb_dest      <= bus.mem_dest_reg;
      wb_data      <= bus.mem_mem_to_reg ? bus.mem_load_data : bus.mem_alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_total_q <= '0;
      for (int i = 0; i < 4; i++) cnt_class[i] <= '0;
    end else if (retire) begin
      cnt_total_q                    <= sat_inc(cnt_total_q);
      cnt_class[bus.mem_instr_class] <= sat_inc(cnt_class[bus.mem_instr_class]);
    end
  end

  assign bus.rf_we     = wb_valid && wb_reg_write && (wb_dest != '0);
  assign bus.rf_waddr  = wb_valid ? wb_dest : '0;
  assign bus.rf_wdata  = wb_valid ? wb_data : '0;
  assign bus.fwd_valid = bus.rf_we;
  assign bus.fwd_reg   = bus.rf_waddr;
  assign bus.fwd_data  = bus.rf_wdata;
  assign bus.halted    = (state == HALTED);
  assign bus.cnt_total = cnt_total_q;
  assign bus.cnt_arith = cnt_class[0];
  assign bus.cnt_logic = cnt_class[1];
  assign bus.cnt_mem   = cnt_class[2];
  assign bus.cnt_ctrl  = cnt_class[3];
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second instance with 2-bit counters shares the
// same stimulus to exercise counter saturation.
module tb_wb_stage;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  wb_stage_if bus ();
  wb_stage_if #(.CNT_WIDTH(2)) sbus ();

  wb_stage dut  (.clk(clk), .reset(reset), .bus(bus));
  wb_stage #(.CNT_WIDTH(2)) sdut (.clk(clk), .reset(reset), .bus(sbus));

  assign sbus.mem_valid       = bus.mem_valid;
  assign sbus.mem_load_data   = bus.mem_load_data;
  assign sbus.mem_alu_result  = bus.mem_alu_result;
  assign sbus.mem_dest_reg    = bus.mem_dest_reg;
  assign sbus.mem_reg_write   = bus.mem_reg_write;
  assign sbus.mem_mem_to_reg  = bus.mem_mem_to_reg;
  assign sbus.mem_instr_class = bus.mem_instr_class;
  assign sbus.mem_is_halt     = bus.mem_is_halt;
  assign sbus.wb_stall        = bus.wb_stall;
  assign sbus.wb_flush        = bus.wb_flush;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [31:0] ld,
                       input logic [31:0] alu, input logic [4:0] dest, input logic [1:0] cls,
                       input logic halt);
    bus.mem_valid       = v;
    bus.mem_reg_write   = rw;
    bus.mem_mem_to_reg  = m2r;
    bus.mem_load_data   = ld;
    bus.mem_alu_result  = alu;
    bus.mem_dest_reg    = dest;
    bus.mem_instr_class = cls;
    bus.mem_is_halt     = halt;
  endtask

  initial begin
    reset        = 1'b0;
    bus.wb_stall = 1'b0;
    bus.wb_flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
    #1;
    check("rst_rf_we",     32'(bus.rf_we),     32'd0);
    check("rst_rf_waddr",  32'(bus.rf_waddr),  32'd0);
    check("rst_rf_wdata",  bus.rf_wdata,       32'd0);
    check("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
    check("rst_halted",    32'(bus.halted),    32'd0);
    check("rst_cnt_total", bus.cnt_total,      32'd0);
    step();
    reset = 1'b1;

    // ADD r5 = 7
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h7, 5'd5, 2'd0, 1'b0);
    step();
    check("add_rf_we",     32'(bus.rf_we),     32'd1);
    check("add_rf_waddr",  32'(bus.rf_waddr),  32'd5);
    check("add_rf_wdata",  bus.rf_wdata,       32'd7);
    check("add_fwd_valid", 32'(bus.fwd_valid), 32'd1);
    check("add_fwd_reg",   32'(bus.fwd_reg),   32'd5);
    check("add_fwd_data",  bus.fwd_data,       32'd7);
    check("add_cnt_total", bus.cnt_total,      32'd1);
    check("add_cnt_arith", bus.cnt_arith,      32'd1);
    check("sat_total_1",   32'(sbus.cnt_total), 32'd1);

    // LW r8 selects load data
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h100, 5'd8, 2'd2, 1'b0);
    step();
    check("ld_rf_waddr",  32'(bus.rf_waddr), 32'd8);
    check("ld_rf_wdata",  bus.rf_wdata,      32'hDEAD_BEEF);
    check("ld_cnt_mem",   bus.cnt_mem,       32'd1);
    check("ld_cnt_total", bus.cnt_total,     32'd2);

    // write to $0 suppressed but counted
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd0, 2'd1, 1'b0);
    step();
    check("r0_rf_we",     32'(bus.rf_we), 32'd0);
    check("r0_cnt_total", bus.cnt_total,  32'd3);
    check("r0_cnt_logic", bus.cnt_logic,  32'd1);

    // bubble: outputs zero, counters unchanged
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h99, 5'd9, 2'd0, 1'b0);
    step();
    check("bub_rf_we",     32'(bus.rf_we),    32'd0);
    check("bub_rf_waddr",  32'(bus.rf_waddr), 32'd0);
    check("bub_rf_wdata",  bus.rf_wdata,      32'd0);
    check("bub_cnt_total", bus.cnt_total,     32'd3);

    // instr A, then held three cycles while new inputs wait
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hA0, 5'd10, 2'd0, 1'b0);
    step();
    check("a_rf_waddr",  32'(bus.rf_waddr), 32'd10);
    check("a_cnt_total", bus.cnt_total,     32'd4);
    check("a_cnt_arith", bus.cnt_arith,     32'd2);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hB0, 5'd11, 2'd1, 1'b0);
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rf_waddr",  32'(bus.rf_waddr), 32'd10);
      check("stall_rf_wdata",  bus.rf_wdata,      32'hA0);
      check("stall_cnt_total", bus.cnt_total,     32'd4);
    end
    bus.wb_stall = 1'b0;
    step();
    check("b_rf_waddr",  32'(bus.rf_waddr), 32'd11);
    check("b_rf_wdata",  bus.rf_wdata,      32'hB0);
    check("b_cnt_total", bus.cnt_total,     32'd5);
    check("b_cnt_logic", bus.cnt_logic,     32'd2);

    // stall and flush together: flush wins
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC0, 5'd12, 2'd0, 1'b0);
    bus.wb_stall = 1'b1;
    bus.wb_flush = 1'b1;
    step();
    check("flush_rf_we",     32'(bus.rf_we), 32'd0);
    check("flush_cnt_total", bus.cnt_total,  32'd5);
    bus.wb_stall = 1'b0;
    bus.wb_flush = 1'b0;

    // HALT with reg_write=1, then an ADD to r3 that must not retire
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd7, 2'd3, 1'b1);
    step();
    check("halt_halted",    32'(bus.halted), 32'd1);
    check("halt_rf_we",     32'(bus.rf_we),  32'd0);
    check("halt_cnt_ctrl",  bus.cnt_ctrl,    32'd1);
    check("halt_cnt_total", bus.cnt_total,   32'd6);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h33, 5'd3, 2'd0, 1'b0);
    bus.wb_stall = 1'b1;
    step();
    step();
    check("post_halted",    32'(bus.halted),   32'd1);
    check("post_rf_we",     32'(bus.rf_we),    32'd0);
    check("post_rf_waddr",  32'(bus.rf_waddr), 32'd0);
    check("post_cnt_total", bus.cnt_total,     32'd6);
    check("post_cnt_arith", bus.cnt_arith,     32'd2);
    bus.wb_stall = 1'b0;

    // 2-bit counters: six retirements saturate total at 3
    check("sat_total", 32'(sbus.cnt_total), 32'd3);
    check("sat_logic", 32'(sbus.cnt_logic), 32'd2);
    check("sat_ctrl",  32'(sbus.cnt_ctrl),  32'd1);

    // asynchronous reset mid-cycle
    reset = 1'b0;
    #1;
    check("arst_halted",    32'(bus.halted),   32'd0);
    check("arst_cnt_total", bus.cnt_total,     32'd0);
    check("arst_cnt_ctrl",  bus.cnt_ctrl,      32'd0);
    check("arst_rf_waddr",  32'(bus.rf_waddr), 32'd0);
    #2;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h44, 5'd4, 2'd0, 1'b0);
    step();
    check("rel_rf_we",     32'(bus.rf_we),    32'd1);
    check("rel_rf_waddr",  32'(bus.rf_waddr), 32'd4);
    check("rel_rf_wdata",  bus.rf_wdata,      32'h44);
    check("rel_cnt_total", bus.cnt_total,     32'd1);
    check("rel_cnt_arith", bus.cnt_arith,     32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
